ball_renderer: RTL and testbench
================================

Name: ball_renderer

Overview:
- Downstream consumer of the trajectory stage's per-ball coordinate vectors.
- Captures each trajectory update into shadow registers and promotes it to active registers at frame start, so a frame never mixes two updates.
- Rasterises up to 8 filled circular balls against the video pixel stream, driving RGB into the display pipeline with fixed latency.

Parameters:
- RADIUS, 8: ball radius in pixels; a pixel hits when dx*dx+dy*dy <= RADIUS*RADIUS.
- Y_BASE, 600: screen row of hand height; screen_y = Y_BASE - traj_y.
- X_OFFSET, 100: screen column added to traj_x.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- traj_x_in[7:0]  input  11 each  ball x (pixels, relative to left hand)
- traj_y_in[7:0]  input  10 each  ball height above hand (pixels)
- traj_valid_in  input  1  coordinate vector valid this cycle
- num_balls_in  input  3  active ball count; 0 = draw nothing
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- data_valid_in  input  1  pixel is in active video
- new_frame_in  input  1  single-cycle pulse at frame start
- red_out  output  8  pixel red
- green_out  output  8  pixel green
- blue_out  output  8  pixel blue
- pixel_valid_out  output  1  data_valid_in delayed to match RGB
- pending_out  output  1  shadow holds an update not yet promoted

Behaviour:
- Reset: all shadow/active coords 0, active count 0 (nothing drawn), pipeline valids 0, RGB 0, pixel_valid_out 0, pending_out 0.
- Capture: on traj_valid_in, shadow coords and num_balls_in latched; pending set. A later valid before promotion overwrites the shadow (last wins).
- Promote: on new_frame_in with pending=1, active <= shadow, pending cleared next cycle. With pending=0, active unchanged.
- Simultaneous traj_valid_in and new_frame_in: active loads the pre-update shadow contents (only if pending was 1); the new vector enters the shadow; pending ends at 1.
- Pipeline, 3 cycles from hcount/vcount/data_valid_in to outputs:
  - S1: per ball, dx = hcount - (traj_x + X_OFFSET) and dy = vcount - (Y_BASE - traj_y), both 12-bit signed. A ball is off-screen (never hits) if traj_y > Y_BASE.
  - S2: dx*dx + dy*dy into 25-bit unsigned; ball i is enabled only when i < active count.
  - S3: compare against RADIUS*RADIUS; the lowest-index hitting ball wins; colour from the colour rule; no hit -> RGB 0.
- pixel_valid_out = data_valid_in delayed 3 cycles. RGB is forced 0 when the delayed data_valid is 0.
- Coordinates are used as unsigned; no wrap-around into the opposite screen edge (12-bit signed differences cover the full range).
- Reset mid-frame: pipeline flushes, outputs 0 on the next cycle, nothing drawn until a capture followed by new_frame_in.

Optional Feature:
- Macro BALL_PALETTE_EN.
- Defined: ball i uses 8-entry fixed palette: 0 red FF0000, 1 green 00FF00, 2 blue 0000FF, 3 yellow FFFF00, 4 cyan 00FFFF, 5 magenta FF00FF, 6 orange FF8000, 7 white FFFFFF.
- Undefined: every ball is white FFFFFF; palette logic absent.

Test Plan:
- Reset then stream a frame with no traj_valid_in -> RGB 0 everywhere; pixel_valid_out tracks data_valid_in delayed 3 cycles.
- Ball0 x=0 y=0, num_balls=1, valid then new_frame -> pixel (100,600) white/red 3 cycles later; (108,600) hit; (109,600) and (100,609) miss.
- Update mid-frame: x0 changes 0->50 -> current frame unchanged at (100,600); after the next new_frame, hit at (150,600), miss at (100,600).
- Balls 0 and 1 both at x=20 y=100 -> (120,500) shows ball 0 colour (FF0000 with BALL_PALETTE_EN); num_balls=1 with ball 1 only at x=200 -> no draw at (300,600-y1).
- traj_valid_in and new_frame_in same cycle with pending=0 -> active unchanged, pending_out=1; next new_frame promotes and clears pending.
- traj_y=700 > Y_BASE -> ball never drawn; reset asserted mid-line -> RGB 0 and pixel_valid_out 0 on the following cycle.

Source files
------------

// File: rtl/ball_renderer.sv
// ball_renderer: draws up to 8 filled circular balls over the pixel stream.
// Trajectory updates are held in a shadow bank and made active at frame
// start. The pixel pipeline has three stages; pixel_valid_out matches RGB.
// Ports:
//   clk_in, rst_in          pixel clock, sync active-high reset
//   traj_x_in/traj_y_in     per-ball coordinates, traj_valid_in strobe
//   num_balls_in            ball count captured with each update
//   hcount_in/vcount_in     pixel position, data_valid_in active video
//   new_frame_in            frame start pulse
//   red/green/blue_out      pixel colour, pixel_valid_out, pending_out
// Macro BALL_PALETTE_EN: per-ball palette; when undefined all balls white.
module ball_renderer #(
  parameter int RADIUS   = 8,
  parameter int Y_BASE   = 600,
  parameter int X_OFFSET = 100
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [7:0][10:0] traj_x_in,
  input  logic [7:0][9:0]  traj_y_in,
  input  logic            traj_valid_in,
  input  logic [2:0]      num_balls_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            data_valid_in,
  input  logic            new_frame_in,
  output logic [7:0]      red_out,
  output logic [7:0]      green_out,
  output logic [7:0]      blue_out,
  output logic            pixel_valid_out,
  output logic            pending_out
);

  localparam logic [24:0] R2 = 25'(RADIUS * RADIUS);

  logic [10:0] r_sx [8];
  logic [9:0]  r_sy [8];
  logic [2:0]  r_sn;
  logic [10:0] r_ax [8];
  logic [9:0]  r_ay [8];
  logic [2:0]  r_an;
  logic        r_pend;

  logic [11:0] r_dx [8];
  logic [11:0] r_dy [8];
  logic [7:0]  r_off1;
  logic        r_v1;

  logic [24:0] r_sq [8];
  logic [7:0]  r_en2;
  logic        r_v2;

  logic [11:0] w_dx [8];
  logic [11:0] w_dy [8];
  logic [24:0] w_sq [8];
  logic        w_hit;
  logic [23:0] w_rgb;
`ifdef BALL_PALETTE_EN
  logic [2:0]  w_idx;
`endif

  function automatic logic [11:0] f_abs(input logic [11:0] a);
    return a[11] ? (~a + 12'd1) : a;
  endfunction

  assign pending_out = r_pend;

  // Shadow/active banks. On a coincident update and frame start the
  // active bank takes the old shadow, and the new vector stays pending.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
        r_ax[i] <= '0;
        r_ay[i] <= '0;
      end
      r_sn   <= '0;
      r_an   <= '0;
      r_pend <= 1'b0;
    end else begin
      if (new_frame_in && r_pend) begin
        for (int i = 0; i < 8; i++) begin
          r_ax[i] <= r_sx[i];
          r_ay[i] <= r_sy[i];
        end
        r_an <= r_sn;
      end
      if (traj_valid_in) begin
        for (int i = 0; i < 8; i++) begin
          r_sx[i] <= traj_x_in[i];
          r_sy[i] <= traj_y_in[i];
        end
        r_sn   <= num_balls_in;
        r_pend <= 1'b1;
      end else if (new_frame_in) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_dx[i] = {1'b0, hcount_in} - {1'b0, r_ax[i]}
              - 12'(X_OFFSET);
      w_dy[i] = {2'b0, vcount_in}
              - (12'(Y_BASE) - {2'b0, r_ay[i]});
    end
  end

  always_comb begin
    logic [11:0] ax;
    logic [11:0] ay;
    logic [23:0] px;
    logic [23:0] py;
    for (int i = 0; i < 8; i++) begin
      ax = f_abs(r_dx[i]);
      ay = f_abs(r_dy[i]);
      px = ax * ax;
      py = ay * ay;
      w_sq[i] = {1'b0, px} + {1'b0, py};
    end
  end

  // Scan high to low so the lowest-index hit is the one kept.
  always_comb begin
    w_hit = 1'b0;
`ifdef BALL_PALETTE_EN
    w_idx = 3'd0;
`endif
    for (int i = 7; i >= 0; i--) begin
      if (r_en2[i] && (r_sq[i] <= R2)) begin
        w_hit = 1'b1;
`ifdef BALL_PALETTE_EN
        w_idx = 3'(i);
`endif
      end
    end
  end

`ifdef BALL_PALETTE_EN
  always_comb begin
    w_rgb = 24'hFFFFFF;
    unique case (w_idx)
      3'd0: w_rgb = 24'hFF0000;
      3'd1: w_rgb = 24'h00FF00;
      3'd2: w_rgb = 24'h0000FF;
      3'd3: w_rgb = 24'hFFFF00;
      3'd4: w_rgb = 24'h00FFFF;
      3'd5: w_rgb = 24'hFF00FF;
      3'd6: w_rgb = 24'hFF8000;
      3'd7: w_rgb = 24'hFFFFFF;
    endcase
  end
`else
  assign w_rgb = 24'hFFFFFF;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) begin
        r_dx[i] <= '0;
        r_dy[i] <= '0;
        r_sq[i] <= '0;
      end
      r_off1          <= '0;
      r_en2           <= '0;
      r_v1            <= 1'b0;
      r_v2            <= 1'b0;
      red_out         <= '0;
      green_out       <= '0;
      blue_out        <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_dx[i]   <= w_dx[i];
        r_dy[i]   <= w_dy[i];
        r_off1[i] <= r_ay[i] > 10'(Y_BASE);
        r_sq[i]   <= w_sq[i];
        r_en2[i]  <= (4'(i) < {1'b0, r_an}) && !r_off1[i];
      end
      r_v1            <= data_valid_in;
      r_v2            <= r_v1;
      pixel_valid_out <= r_v2;
      if (r_v2 && w_hit) begin
        red_out   <= w_rgb[23:16];
        green_out <= w_rgb[15:8];
        blue_out  <= w_rgb[7:0];
      end else begin
        red_out   <= '0;
        green_out <= '0;
        blue_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// tb_ball_renderer: directed vectors for ball_renderer.
// Table-driven pixel checks plus capture/promote/reset sequences.
module tb_ball_renderer;

`ifdef BALL_PALETTE_EN
  localparam logic [23:0] C0 = 24'hFF0000;
  localparam logic [23:0] C1 = 24'h00FF00;
`else
  localparam logic [23:0] C0 = 24'hFFFFFF;
  localparam logic [23:0] C1 = 24'hFFFFFF;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0][10:0] tx;
  logic [7:0][9:0]  ty;
  logic            tv = 1'b0;
  logic [2:0]      nb = 3'd0;
  logic [10:0]     hc = '0;
  logic [9:0]      vc = '0;
  logic            dv = 1'b0;
  logic            nf = 1'b0;
  logic [7:0]      r, g, b;
  logic            pv, pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_renderer dut (
    .clk_in(clk), .rst_in(rst),
    .traj_x_in(tx), .traj_y_in(ty),
    .traj_valid_in(tv), .num_balls_in(nb),
    .hcount_in(hc), .vcount_in(vc),
    .data_valid_in(dv), .new_frame_in(nf),
    .red_out(r), .green_out(g), .blue_out(b),
    .pixel_valid_out(pv), .pending_out(pend)
  );

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        d;
    logic [23:0] rgb;
    logic        p;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic pix(input string nm, input logic [10:0] h,
                     input logic [9:0] v, input logic d,
                     input logic [23:0] rgb);
    @(negedge clk);
    hc = h; vc = v; dv = d;
    repeat (3) @(posedge clk);
    #1;
    chk(nm, {7'd0, pv, r, g, b}, {7'd0, d, rgb});
  endtask

  task automatic load(input logic [2:0] n);
    @(negedge clk);
    nb = n; tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    tx = '0; ty = '0;
    pat = 10'b1011001101;

    tbl[0] = '{11'd100, 10'd600, 1'b1, C0, 1'b1};
    tbl[1] = '{11'd108, 10'd600, 1'b1, C0, 1'b1};
    tbl[2] = '{11'd109, 10'd600, 1'b1, 24'h0, 1'b1};
    tbl[3] = '{11'd100, 10'd609, 1'b1, 24'h0, 1'b1};
    tbl[4] = '{11'd92,  10'd600, 1'b1, C0, 1'b1};
    tbl[5] = '{11'd100, 10'd592, 1'b1, C0, 1'b1};
    tbl[6] = '{11'd106, 10'd606, 1'b1, 24'h0, 1'b1};
    tbl[7] = '{11'd105, 10'd606, 1'b1, C0, 1'b1};
    tbl[8] = '{11'd100, 10'd600, 1'b0, 24'h0, 1'b0};
    tbl[9] = '{11'd91,  10'd600, 1'b1, 24'h0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
    chk("rst_pv", {31'd0, pv}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pix("empty_a", 11'd100, 10'd600, 1'b1, 24'h0);
    pix("empty_b", 11'd0, 10'd0, 1'b1, 24'h0);
    pix("empty_c", 11'd5, 10'd5, 1'b0, 24'h0);

    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      hc = 11'd100; vc = 10'd600;
      dv = (j < 10) ? pat[j] : 1'b0;
      @(posedge clk);
      #1;
      if (j >= 2)
        chk("pv_delay", {31'd0, pv}, {31'd0, pat[j-2]});
    end

    tx[0] = 11'd0; ty[0] = 10'd0;
    load(3'd1);
    #1;
    chk("pend_set", {31'd0, pend}, 32'd1);
    pix("pre_promote", 11'd100, 10'd600, 1'b1, 24'h0);
    frame();
    #1;
    chk("pend_clr", {31'd0, pend}, 32'd0);
    for (int i = 0; i < 10; i++)
      pix($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v,
          tbl[i].d, tbl[i].rgb);

    tx[0] = 11'd50;
    load(3'd1);
    pix("mid_old", 11'd100, 10'd600, 1'b1, C0);
    pix("mid_new_no", 11'd150, 10'd600, 1'b1, 24'h0);
    frame();
    pix("nf_new", 11'd150, 10'd600, 1'b1, C0);
    pix("nf_old_no", 11'd100, 10'd600, 1'b1, 24'h0);

    tx[0] = 11'd20; ty[0] = 10'd100;
    tx[1] = 11'd20; ty[1] = 10'd100;
    load(3'd2); frame();
    pix("prio0", 11'd120, 10'd500, 1'b1, C0);
    tx[0] = 11'd500; ty[0] = 10'd0;
    load(3'd2); frame();
    pix("ball1", 11'd120, 10'd500, 1'b1, C1);
    tx[0] = 11'd0; ty[0] = 10'd0;
    tx[1] = 11'd200; ty[1] = 10'd100;
    load(3'd1); frame();
    pix("cnt_gate", 11'd300, 10'd500, 1'b1, 24'h0);
    load(3'd0); frame();
    pix("cnt_zero", 11'd100, 10'd600, 1'b1, 24'h0);

    tx[0] = 11'd0; ty[0] = 10'd0;
    load(3'd1); frame();
    tx[0] = 11'd300;
    @(negedge clk);
    nb = 3'd1; tv = 1'b1; nf = 1'b1;
    @(negedge clk);
    tv = 1'b0; nf = 1'b0;
    #1;
    chk("sim0_pend", {31'd0, pend}, 32'd1);
    pix("sim0_keep", 11'd100, 10'd600, 1'b1, C0);
    pix("sim0_no", 11'd400, 10'd600, 1'b1, 24'h0);
    frame();
    #1;
    chk("sim0_clr", {31'd0, pend}, 32'd0);
    pix("sim0_new", 11'd400, 10'd600, 1'b1, C0);

    tx[0] = 11'd600;
    load(3'd1);
    tx[0] = 11'd700;
    @(negedge clk);
    tv = 1'b1; nf = 1'b1;
    @(negedge clk);
    tv = 1'b0; nf = 1'b0;
    #1;
    chk("sim1_pend", {31'd0, pend}, 32'd1);
    pix("sim1_old", 11'd700, 10'd600, 1'b1, C0);
    pix("sim1_no", 11'd800, 10'd600, 1'b1, 24'h0);
    frame();
    pix("sim1_new", 11'd800, 10'd600, 1'b1, C0);

    tx[0] = 11'd0; ty[0] = 10'd700;
    load(3'd1); frame();
    pix("offy_a", 11'd100, 10'd0, 1'b1, 24'h0);
    pix("offy_b", 11'd100, 10'd600, 1'b1, 24'h0);

    ty[0] = 10'd0;
    load(3'd1); frame();
    pix("pre_rst", 11'd100, 10'd600, 1'b1, C0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst", {7'd0, pv, r, g, b}, 32'd0);
    chk("mid_rst_pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pix("post_rst", 11'd100, 10'd600, 1'b1, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
